// File: rtl/store_buffer.sv
// store_buffer: circular store queue. Dispatch allocates, the LSU fills in address/data,
// ROB retire commits, and committed stores drain in order; loads get forwarded data.
// Latency: alloc/LSU/retire take effect on the next edge; SB_Addr*, drain and forwarding are combinational.
// Backpressure: SB_stall while fewer than two entries are free; the drain holds until Mem_W_Ready.
// Ports:
//   CLK, RST (sync, active high), Flush
//   Alloc1_V/Alloc2_V -> SB_Addr1/SB_Addr2, SB_stall          dispatch allocation
//   LSU_St_V/Idx/Addr/Data                                    store execution
//   ROB_Retire{1,2}_SB_V/Addr                                 in-order commit
//   Mem_W_V/Addr/Data <- Mem_W_Ready                          memory drain
//   Ld_Addr -> Fwd_Hit/Fwd_Data                               load forwarding
module store_buffer #(
    parameter int SB_SIZE = 5,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Flush,
    input  logic               Alloc1_V,
    input  logic               Alloc2_V,
    output logic [SB_SIZE-1:0] SB_Addr1,
    output logic [SB_SIZE-1:0] SB_Addr2,
    output logic               SB_stall,
    input  logic               LSU_St_V,
    input  logic [SB_SIZE-1:0] LSU_St_Idx,
    input  logic [ADDR_W-1:0]  LSU_St_Addr,
    input  logic [DATA_W-1:0]  LSU_St_Data,
    input  logic               ROB_Retire1_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
    input  logic               ROB_Retire2_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
    output logic               Mem_W_V,
    output logic [ADDR_W-1:0]  Mem_W_Addr,
    output logic [DATA_W-1:0]  Mem_W_Data,
    input  logic               Mem_W_Ready,
    input  logic [ADDR_W-1:0]  Ld_Addr,
    output logic               Fwd_Hit,
    output logic [DATA_W-1:0]  Fwd_Data
);

    localparam int DEPTH = 1 << SB_SIZE;
    localparam logic [SB_SIZE:0] STALL_CNT = (SB_SIZE + 1)'(DEPTH - 1);

    typedef logic [SB_SIZE-1:0] idx_t;
    typedef logic [SB_SIZE:0]   cnt_t;

    // Per-entry flags kept as bit vectors so the next-state logic can work on whole vectors.
    logic [DEPTH-1:0] busy, exec, commit;
    logic [DEPTH-1:0] busy_n, exec_n, commit_n;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    idx_t head, cmt, tail;
    idx_t head_n, cmt_n, tail_n;
    // count: all live entries; ncmt: the committed subset, which is what survives a flush.
    cnt_t count, ncmt;
    cnt_t count_n, ncmt_n;

    logic       alloc_ok, lsu_ok, drain;
    logic [1:0] n_alloc, n_ret;
    idx_t       ret2_exp;
    idx_t       fi;

    assign SB_Addr1 = tail;
    assign SB_Addr2 = tail + idx_t'(1);
    assign SB_stall = (count >= STALL_CNT);

    assign Mem_W_V    = busy[head] & exec[head] & commit[head];
    assign Mem_W_Addr = addr_q[head];
    assign Mem_W_Data = data_q[head];
    assign drain      = Mem_W_V & Mem_W_Ready;

    // Allocation while stalled is ignored rather than allowed to overrun the head.
    assign alloc_ok = ~Flush & ~SB_stall;
    assign n_alloc  = alloc_ok ? ({1'b0, Alloc1_V} + {1'b0, Alloc2_V}) : 2'd0;
    assign n_ret    = {1'b0, ROB_Retire1_SB_V} + {1'b0, ROB_Retire2_SB_V};
    assign lsu_ok   = LSU_St_V & busy[LSU_St_Idx] & ~commit[LSU_St_Idx];

    assign cmt_n  = cmt + idx_t'(n_ret);
    assign head_n = head + idx_t'(drain);
    assign ncmt_n = ncmt + cnt_t'(n_ret) - cnt_t'(drain);
    // A flush rewinds tail to the commit point; only committed entries remain counted.
    assign tail_n  = Flush ? cmt_n : tail + idx_t'(n_alloc);
    assign count_n = Flush ? ncmt_n : count + cnt_t'(n_alloc) - cnt_t'(drain);

    always_comb begin
        busy_n   = busy;
        exec_n   = exec;
        commit_n = commit;
        if (lsu_ok) begin
            exec_n[LSU_St_Idx] = 1'b1;
        end
        if (ROB_Retire1_SB_V) begin
            commit_n[ROB_Retire1_SB_Addr] = 1'b1;
        end
        if (ROB_Retire2_SB_V) begin
            commit_n[ROB_Retire2_SB_Addr] = 1'b1;
        end
        if (drain) begin
            busy_n[head]   = 1'b0;
            exec_n[head]   = 1'b0;
            commit_n[head] = 1'b0;
        end
        if (Flush) begin
            // Any entry still uncommitted after this cycle's retires lies in [cmt', tail).
            busy_n = busy_n & commit_n;
            exec_n = exec_n & commit_n;
        end else if (n_alloc != 2'd0) begin
            // A single alloc on either slot takes tail; a pair takes tail and tail+1.
            busy_n[tail]   = 1'b1;
            exec_n[tail]   = 1'b0;
            commit_n[tail] = 1'b0;
            if (n_alloc == 2'd2) begin
                busy_n[tail + idx_t'(1)]   = 1'b1;
                exec_n[tail + idx_t'(1)]   = 1'b0;
                commit_n[tail + idx_t'(1)] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy   <= '0;
            exec   <= '0;
            commit <= '0;
            head   <= '0;
            cmt    <= '0;
            tail   <= '0;
            count  <= '0;
            ncmt   <= '0;
        end else begin
            busy   <= busy_n;
            exec   <= exec_n;
            commit <= commit_n;
            head   <= head_n;
            cmt    <= cmt_n;
            tail   <= tail_n;
            count  <= count_n;
            ncmt   <= ncmt_n;
        end
    end

    // Payload is only meaningful while exec is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (lsu_ok) begin
            addr_q[LSU_St_Idx] <= LSU_St_Addr;
            data_q[LSU_St_Idx] <= LSU_St_Data;
        end
    end

    // Walk from oldest slot to youngest (tail-1); a later match overwrites, so the youngest wins.
    // Non-live slots have busy clear, so the whole ring can be scanned without a bounds check.
    always_comb begin
        Fwd_Hit  = 1'b0;
        Fwd_Data = '0;
        fi       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            fi = tail - idx_t'(1) - idx_t'(k);
            if (busy[fi] && exec[fi] && (addr_q[fi] == Ld_Addr)) begin
                Fwd_Hit  = 1'b1;
                Fwd_Data = data_q[fi];
            end
        end
    end

    assign ret2_exp = ROB_Retire1_SB_V ? (cmt + idx_t'(1)) : cmt;

    a_retire1_in_order: assert property (@(posedge CLK) disable iff (RST)
        ROB_Retire1_SB_V |-> (ROB_Retire1_SB_Addr == cmt));
    a_retire2_in_order: assert property (@(posedge CLK) disable iff (RST)
        ROB_Retire2_SB_V |-> (ROB_Retire2_SB_Addr == ret2_exp));

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer; drains are checked in order against a queue.
// Latency: stimulus changes #1 after posedge, outputs checked #1 after posedge or at negedge.
// Backpressure: Mem_W_Ready held low or high by the stimulus to exercise the drain hold.
module tb_store_buffer;
    localparam int SB_SIZE = 5;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;

    logic               CLK = 1'b0;
    logic               RST;
    logic               Flush;
    logic               Alloc1_V, Alloc2_V;
    logic [SB_SIZE-1:0] SB_Addr1, SB_Addr2;
    logic               SB_stall;
    logic               LSU_St_V;
    logic [SB_SIZE-1:0] LSU_St_Idx;
    logic [ADDR_W-1:0]  LSU_St_Addr;
    logic [DATA_W-1:0]  LSU_St_Data;
    logic               ROB_Retire1_SB_V, ROB_Retire2_SB_V;
    logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr, ROB_Retire2_SB_Addr;
    logic               Mem_W_V;
    logic [ADDR_W-1:0]  Mem_W_Addr;
    logic [DATA_W-1:0]  Mem_W_Data;
    logic               Mem_W_Ready;
    logic [ADDR_W-1:0]  Ld_Addr;
    logic               Fwd_Hit;
    logic [DATA_W-1:0]  Fwd_Data;

    always #5 CLK = ~CLK;

    store_buffer #(.SB_SIZE(SB_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .Alloc1_V(Alloc1_V), .Alloc2_V(Alloc2_V),
        .SB_Addr1(SB_Addr1), .SB_Addr2(SB_Addr2), .SB_stall(SB_stall),
        .LSU_St_V(LSU_St_V), .LSU_St_Idx(LSU_St_Idx),
        .LSU_St_Addr(LSU_St_Addr), .LSU_St_Data(LSU_St_Data),
        .ROB_Retire1_SB_V(ROB_Retire1_SB_V), .ROB_Retire1_SB_Addr(ROB_Retire1_SB_Addr),
        .ROB_Retire2_SB_V(ROB_Retire2_SB_V), .ROB_Retire2_SB_Addr(ROB_Retire2_SB_Addr),
        .Mem_W_V(Mem_W_V), .Mem_W_Addr(Mem_W_Addr), .Mem_W_Data(Mem_W_Data),
        .Mem_W_Ready(Mem_W_Ready),
        .Ld_Addr(Ld_Addr), .Fwd_Hit(Fwd_Hit), .Fwd_Data(Fwd_Data)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  m_tail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alloc(input logic a1, input logic a2);
        Alloc1_V = a1;
        Alloc2_V = a2;
        tick();
        Alloc1_V = 1'b0;
        Alloc2_V = 1'b0;
    endtask

    task automatic lsu(input int idx, input int a, input int d);
        LSU_St_V    = 1'b1;
        LSU_St_Idx  = SB_SIZE'(idx);
        LSU_St_Addr = ADDR_W'(a);
        LSU_St_Data = DATA_W'(d);
        tick();
        LSU_St_V = 1'b0;
    endtask

    // Retires one entry (optionally two) and records what must appear on the drain port.
    task automatic retire(input int i1, input int a1, input int d1,
                          input logic two, input int i2, input int a2, input int d2);
        wr_t e;
        ROB_Retire1_SB_V    = 1'b1;
        ROB_Retire1_SB_Addr = SB_SIZE'(i1);
        e.a = ADDR_W'(a1);
        e.d = DATA_W'(d1);
        exp_q.push_back(e);
        if (two) begin
            ROB_Retire2_SB_V    = 1'b1;
            ROB_Retire2_SB_Addr = SB_SIZE'(i2);
            e.a = ADDR_W'(a2);
            e.d = DATA_W'(d2);
            exp_q.push_back(e);
        end
        tick();
        ROB_Retire1_SB_V = 1'b0;
        ROB_Retire2_SB_V = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        Mem_W_Ready = 1'b1;
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
        chk("drain_timeout_left", 32'(exp_q.size()), 0);
        Mem_W_Ready = 1'b0;
    endtask

    // Drain monitor: a handshake seen at negedge completes on the following posedge.
    always @(negedge CLK) begin
        if (!RST && Mem_W_V && Mem_W_Ready) begin
            chk("drain_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("drain_addr", 32'(Mem_W_Addr), 32'(mon_e.a));
                chk("drain_data", 32'(Mem_W_Data), 32'(mon_e.d));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; Flush = 1'b0; Alloc1_V = 1'b0; Alloc2_V = 1'b0;
        LSU_St_V = 1'b0; LSU_St_Idx = '0; LSU_St_Addr = '0; LSU_St_Data = '0;
        ROB_Retire1_SB_V = 1'b0; ROB_Retire1_SB_Addr = '0;
        ROB_Retire2_SB_V = 1'b0; ROB_Retire2_SB_Addr = '0;
        Mem_W_Ready = 1'b0; Ld_Addr = '0;
        repeat (3) tick();
        RST = 1'b0;
        #1;
        chk("rst_mem_w_v", 32'(Mem_W_V), 0);
        chk("rst_fwd_hit", 32'(Fwd_Hit), 0);
        chk("rst_stall", 32'(SB_stall), 0);
        chk("rst_addr1", 32'(SB_Addr1), 0);
        chk("rst_addr2", 32'(SB_Addr2), 1);
        chk("rst_count", 32'(dut.count), 0);

        // Dual allocation from an empty buffer.
        Alloc1_V = 1'b1; Alloc2_V = 1'b1;
        #1;
        chk("t1_addr1", 32'(SB_Addr1), 0);
        chk("t1_addr2", 32'(SB_Addr2), 1);
        tick();
        Alloc1_V = 1'b0; Alloc2_V = 1'b0;
        chk("t1_tail", 32'(SB_Addr1), 2);
        chk("t1_count", 32'(dut.count), 2);

        // Drain held for three cycles of no-ready, accepted on the fourth.
        lsu(0, 16'h0040, 16'hBEEF);
        retire(0, 16'h0040, 16'hBEEF, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_v", 32'(Mem_W_V), 1);
            chk("t2_hold_addr", 32'(Mem_W_Addr), 32'h0040);
            chk("t2_hold_data", 32'(Mem_W_Data), 32'hBEEF);
            tick();
        end
        Mem_W_Ready = 1'b1;
        chk("t2_hold_v", 32'(Mem_W_V), 1);
        tick();
        Mem_W_Ready = 1'b0;
        chk("t2_head", 32'(dut.head), 1);
        chk("t2_sb_left", 32'(exp_q.size()), 0);
        chk("t2_idle_v", 32'(Mem_W_V), 0);
        lsu(1, 16'h0050, 16'h1234);
        retire(1, 16'h0050, 16'h1234, 1'b0, 0, 0, 0);
        wait_drain(10);
        chk("t2_count_empty", 32'(dut.count), 0);

        // Stall boundary: 30 live entries still accepts, 31 stalls, stalled alloc ignored.
        repeat (15) alloc(1'b1, 1'b1);
        chk("t3_stall_at30", 32'(SB_stall), 0);
        chk("t3_count30", 32'(dut.count), 30);
        alloc(1'b1, 1'b0);
        chk("t3_stall_at31", 32'(SB_stall), 1);
        chk("t3_count31", 32'(dut.count), 31);
        chk("t3_tail31", 32'(SB_Addr1), 1);
        alloc(1'b1, 1'b1);
        chk("t3_ignored_tail", 32'(SB_Addr1), 1);
        chk("t3_ignored_count", 32'(dut.count), 31);
        lsu(2, 16'h0200, 16'h2002);
        retire(2, 16'h0200, 16'h2002, 1'b0, 0, 0, 0);
        wait_drain(10);
        chk("t3_unstall", 32'(SB_stall), 0);
        chk("t3_count_after", 32'(dut.count), 30);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("t3_flush_tail", 32'(SB_Addr1), 3);
        chk("t3_flush_count", 32'(dut.count), 0);
        chk("t3_flush_v", 32'(Mem_W_V), 0);

        // Single-store stream through the ring: pointers wrap from 31 to 0.
        m_tail = 3;
        for (int n = 0; n < 29; n++) begin
            chk("t4_addr1", 32'(SB_Addr1), 32'(m_tail));
            if (m_tail == 31) chk("t4_addr2_wrap", 32'(SB_Addr2), 0);
            if (n % 2 == 0) alloc(1'b1, 1'b0);
            else            alloc(1'b0, 1'b1);
            lsu(m_tail, 32'h1000 + n, 32'hC000 + n);
            retire(m_tail, 32'h1000 + n, 32'hC000 + n, 1'b0, 0, 0, 0);
            wait_drain(10);
            m_tail = (m_tail + 1) % 32;
        end
        chk("t4_tail_wrapped", 32'(SB_Addr1), 0);
        chk("t4_head_wrapped", 32'(dut.head), 0);
        chk("t4_count", 32'(dut.count), 0);

        // Flush with two committed entries; retire of idx1 and allocs share the flush cycle.
        alloc(1'b1, 1'b1);
        alloc(1'b1, 1'b1);
        lsu(0, 16'h0100, 16'hA000);
        lsu(1, 16'h0101, 16'hA001);
        lsu(2, 16'h0102, 16'hA002);
        retire(0, 16'h0100, 16'hA000, 1'b0, 0, 0, 0);
        Flush = 1'b1; Alloc1_V = 1'b1; Alloc2_V = 1'b1;
        retire(1, 16'h0101, 16'hA001, 1'b0, 0, 0, 0);
        Flush = 1'b0; Alloc1_V = 1'b0; Alloc2_V = 1'b0;
        chk("t5_tail", 32'(SB_Addr1), 2);
        chk("t5_count", 32'(dut.count), 2);
        chk("t5_idx2_dropped", 32'(dut.busy[2]), 0);
        chk("t5_idx3_dropped", 32'(dut.busy[3]), 0);
        Ld_Addr = 16'h0102;
        #1;
        chk("t5_fwd_flushed", 32'(Fwd_Hit), 0);
        Ld_Addr = 16'h0100;
        #1;
        chk("t5_fwd_cmt_hit", 32'(Fwd_Hit), 1);
        chk("t5_fwd_cmt_data", 32'(Fwd_Data), 32'hA000);
        chk("t5_drain_v", 32'(Mem_W_V), 1);
        wait_drain(10);
        chk("t5_count_empty", 32'(dut.count), 0);
        chk("t5_head", 32'(dut.head), 2);

        // Forwarding: youngest of two matching entries wins.
        alloc(1'b1, 1'b1);
        alloc(1'b1, 1'b0);
        lsu(2, 16'h0010, 16'h1111);
        lsu(3, 16'h0020, 16'h3333);
        lsu(4, 16'h0010, 16'h2222);
        Ld_Addr = 16'h0010;
        #1;
        chk("t6_fwd_hit", 32'(Fwd_Hit), 1);
        chk("t6_fwd_young", 32'(Fwd_Data), 32'h2222);
        Ld_Addr = 16'h0020;
        #1;
        chk("t6_fwd_mid", 32'(Fwd_Data), 32'h3333);
        Ld_Addr = 16'h0030;
        #1;
        chk("t6_fwd_miss_hit", 32'(Fwd_Hit), 0);
        chk("t6_fwd_miss_data", 32'(Fwd_Data), 0);
        retire(2, 16'h0010, 16'h1111, 1'b1, 3, 16'h0020, 16'h3333);
        retire(4, 16'h0010, 16'h2222, 1'b0, 0, 0, 0);
        Ld_Addr = 16'h0010;
        #1;
        chk("t6_fwd_committed", 32'(Fwd_Data), 32'h2222);
        wait_drain(10);
        chk("t6_fwd_after_drain", 32'(Fwd_Hit), 0);
        chk("t6_count", 32'(dut.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
